// File: rtl/exp_taylor_unit.sv
// exp_taylor_unit: fixed-point e^x / e^-x for x in [0,1)
// by an iterative Taylor series on one shared multiplier pair.
module exp_taylor_unit #(
  parameter int FW    = 16,
  parameter int IW    = 2,
  parameter int TERMS = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          neg,
  input  logic [FW-1:0] x,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] intpart,
  output logic [FW-1:0] fracpart
);

  localparam int TW = IW + FW + 1;
  localparam int RW = IW + FW;
  localparam int XW = FW + 1;
  localparam int CW = FW + 2;
  localparam int KW = $clog2(TERMS) + 1;
  localparam int PXW = TW + XW;
  localparam int PRW = TW + CW;

  function automatic logic [TERMS*XW-1:0] mk_recip();
    logic [TERMS*XW-1:0] tab;
    tab = '0;
    for (int i = 1; i < TERMS; i++)
      tab[i*XW +: XW] = XW'((64'd1 << FW) / 64'(i));
    return tab;
  endfunction

  localparam logic [TERMS*XW-1:0] RECIP = mk_recip();

  localparam logic signed [TW-1:0] T_ONE =
    {{IW{1'b0}}, 1'b1, {FW{1'b0}}};
  localparam logic [RW-1:0] R_ONE =
    {{(IW-1){1'b0}}, 1'b1, {FW{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    MULX,
    MULR,
    DONE
  } state_t;

  state_t state, nxt;

  logic signed [TW-1:0]  t;
  logic signed [XW-1:0]  xs;
  logic [RW-1:0]         r;
  logic [RW-1:0]         res;
  logic [KW-1:0]         k;

  logic signed [XW-1:0]  xin;
  logic [XW-1:0]         rk;
  logic signed [CW-1:0]  rc;
  logic signed [PXW-1:0] px;
  logic signed [PRW-1:0] pr;
  logic signed [TW-1:0]  tx;
  logic signed [TW-1:0]  tn;
  logic [RW-1:0]         rn;
  logic                  last;

  assign xin  = signed'({1'b0, x});
  assign rk   = RECIP[int'(k)*XW +: XW];
  assign rc   = signed'({1'b0, rk});
  assign last = (k == KW'(TERMS - 1));

  // full-width signed products, then >>> FW and resize to the term width
  assign px = signed'({{XW{t[TW-1]}}, t}) * signed'({{TW{xs[XW-1]}}, xs});
  assign pr = signed'({{CW{t[TW-1]}}, t}) * signed'({{TW{rc[CW-1]}}, rc});
  assign tx = TW'(px >>> FW);
  assign tn = TW'(pr >>> FW);
  assign rn = RW'({1'b0, r} + $unsigned(tn));

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt  = state;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: if (start) nxt = MULX;
      MULX: begin
        busy = 1'b1;
        nxt  = MULR;
      end
      MULR: begin
        busy = 1'b1;
        nxt  = last ? DONE : MULX;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      t   <= '0;
      xs  <= '0;
      r   <= '0;
      res <= '0;
      k   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          xs <= neg ? -xin : xin;
          t  <= T_ONE;
          r  <= R_ONE;
          k  <= KW'(1);
        end
        MULX: t <= tx;
        MULR: begin
          t <= tn;
          r <= rn;
          k <= k + 1'b1;
          if (last) res <= rn;
        end
        default: ;
      endcase
    end
  end

  assign intpart  = res[RW-1:FW];
  assign fracpart = res[FW-1:0];

endmodule
